// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with a valid/ready handshake, a two-entry skid buffer and a NOP-inserting flush.
// Optional stall/back-pressure counters are enabled with the PIPE_STAGE_PERF_EN macro.
//
// state | meaning
// EMPTY | no live bundle; out_data = NOP_WORD
// ONE   | main register holds a live bundle, skid empty
// TWO   | main and skid both hold bundles; in_ready = 0
module pipe_stage_skid #(
  parameter int unsigned        DATA_W   = 32,
  parameter logic [DATA_W-1:0]  NOP_WORD = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bp_cnt
`endif
);

  // bit0 = out_valid, bit1 = skid_valid; 2'b10 is the unreachable illegal pair
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] skid_data, skid_data_d;
  logic [DATA_W-1:0] out_data_d;
  logic              skid_valid;
  logic              in_fire, out_fire;

  assign out_valid  = state_q[0];
  assign skid_valid = state_q[1];
  assign in_ready   = ~skid_valid;
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_q   <= EMPTY;
      out_data  <= NOP_WORD;
      skid_data <= NOP_WORD;
    end else begin
      state_q   <= state_d;
      out_data  <= out_data_d;
      skid_data <= skid_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data;
    skid_data_d = skid_data;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          out_data_d = in_data;
          state_d    = ONE;
        end
      end
      ONE: begin
        if (out_fire && in_fire) begin
          out_data_d = in_data;
        end else if (out_fire) begin
          out_data_d = NOP_WORD;
          state_d    = EMPTY;
        end else if (in_fire) begin
          skid_data_d = in_data;
          state_d     = TWO;
        end
      end
      TWO: begin
        if (out_fire) begin
          out_data_d  = skid_data;
          skid_data_d = NOP_WORD;
          state_d     = ONE;
        end
      end
      default: begin
        state_d     = EMPTY;
        out_data_d  = NOP_WORD;
        skid_data_d = NOP_WORD;
      end
    endcase
  end

`ifdef PIPE_STAGE_PERF_EN
  // Counters ignore flush so stall history survives pipeline redirects.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'd0;
      bp_cnt    <= 32'd0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (in_valid && !in_ready && (bp_cnt != 32'hFFFF_FFFF))
        bp_cnt <= bp_cnt + 32'd1;
    end
  end
`endif

endmodule
